// File: rtl/axi_pwr_ctrl_pkg.sv
// Shared types and helpers for the AXI slice power controller.
package axi_pwr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ISOLATED = 2'd2,
    ST_SLEEP    = 2'd3
  } pwr_state_e;

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/axi_pwr_ctrl_cnt.sv
// Saturating up/down transaction counter; flags an error on over/underflow.
module axi_pwr_ctrl_cnt #(
  parameter int MAX        = 16,
  parameter int W          = 5,
  parameter bit SIGNED_CNT = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         err_o
);

  // Signed mode saturates symmetrically at -MAX; unsigned mode floors at 0.
  localparam logic [W-1:0] HI = W'(MAX);
  localparam logic [W-1:0] LO = SIGNED_CNT ? W'(-MAX) : W'(0);

  logic [W-1:0] cnt_d, cnt_q;
  logic         err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == HI) err_d = 1'b1;
      else             cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == LO) err_d = 1'b1;
      else             cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign err_o = err_d;

endmodule

// File: rtl/axi_slice_dc_pwr_ctrl.sv
// Quiesces, isolates and clock-gates an AXI dual-clock slice on request,
// tracking outstanding transactions on the master side.
module axi_slice_dc_pwr_ctrl
  import axi_pwr_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int WAKE_ON_REQ     = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic isolate_req_i,
  input  logic clock_down_req_i,
  input  logic incoming_req_i,
  input  logic aw_valid_i,
  input  logic aw_ready_i,
  input  logic ar_valid_i,
  input  logic ar_ready_i,
  input  logic w_valid_i,
  input  logic w_ready_i,
  input  logic w_last_i,
  input  logic r_valid_i,
  input  logic r_ready_i,
  input  logic r_last_i,
  input  logic b_valid_i,
  input  logic b_ready_i,
  output logic gate_addr_o,
  output logic isolate_o,
  output logic clock_down_o,
  output logic isolate_ack_o,
  output logic wakeup_o,
  output logic err_o
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);
  localparam int PW = CW + 1;

  logic aw_hs, ar_hs, w_hs, r_hs, b_hs, any_hs;
  assign aw_hs  = aw_valid_i & aw_ready_i;
  assign ar_hs  = ar_valid_i & ar_ready_i;
  assign w_hs   = w_valid_i & w_ready_i;
  assign r_hs   = r_valid_i & r_ready_i;
  assign b_hs   = b_valid_i & b_ready_i;
  assign any_hs = aw_hs | ar_hs | w_hs | r_hs | b_hs;

  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [PW-1:0] wp_cnt;
  logic          wr_err, rd_err, wp_err;

  axi_pwr_ctrl_cnt #(.MAX(MAX_OUTSTANDING), .W(CW), .SIGNED_CNT(1'b0)) u_wr_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(aw_hs), .dec_i(b_hs),
    .cnt_o(wr_cnt), .err_o(wr_err));

  axi_pwr_ctrl_cnt #(.MAX(MAX_OUTSTANDING), .W(CW), .SIGNED_CNT(1'b0)) u_rd_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(ar_hs), .dec_i(r_hs & r_last_i),
    .cnt_o(rd_cnt), .err_o(rd_err));

  // W may lead AW, so the write-data balance runs signed.
  axi_pwr_ctrl_cnt #(.MAX(MAX_OUTSTANDING), .W(PW), .SIGNED_CNT(1'b1)) u_wp_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(aw_hs), .dec_i(w_hs & w_last_i),
    .cnt_o(wp_cnt), .err_o(wp_err));

  pwr_state_e state_d, state_q;
  logic       wake_block_d, wake_block_q;
  logic       wakeup_d, wakeup_q;
  logic       err_d, err_q;
  logic       idle, wake_by_req, in_iso;

  assign idle        = (wr_cnt == '0) && (rd_cnt == '0) && (wp_cnt == '0);
  assign wake_by_req = (WAKE_ON_REQ != 0) && incoming_req_i;
  assign in_iso      = (state_q == ST_ISOLATED) || (state_q == ST_SLEEP);

  always_comb begin
    state_d      = state_q;
    wakeup_d     = 1'b0;
    wake_block_d = clock_down_req_i ? wake_block_q : 1'b0;
    err_d        = err_q | wr_err | rd_err | wp_err | (in_iso & any_hs);
    case (state_q)
      ST_RUN: if (isolate_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!isolate_req_i)                      state_d = ST_RUN;
        else if (idle && !aw_hs && !ar_hs)       state_d = ST_ISOLATED;
      end
      ST_ISOLATED: begin
        if (!isolate_req_i)                      state_d = ST_RUN;
        else if (clock_down_req_i && !wake_block_q) state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (!clock_down_req_i || wake_by_req) state_d = ST_ISOLATED;
        // A request-driven wake holds off SLEEP until clock_down_req_i drops.
        if (wake_by_req) begin
          wakeup_d = 1'b1;
          if (clock_down_req_i) wake_block_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      wake_block_q <= 1'b0;
      wakeup_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wake_block_q <= wake_block_d;
      wakeup_q     <= wakeup_d;
      err_q        <= err_d;
    end
  end

  assign gate_addr_o   = (state_q != ST_RUN);
  assign isolate_o     = in_iso;
  assign isolate_ack_o = in_iso;
  assign clock_down_o  = (state_q == ST_SLEEP);
  assign wakeup_o      = wakeup_q;
  assign err_o         = err_q;

endmodule
